// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack evaluator: op codes, error bit indices, FSM states.
// Optional multiply support is enabled by defining RPN_MUL_EN.
package rpn_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_OR  = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;

   localparam int ERR_OVF  = 0;
   localparam int ERR_UNF  = 1;
   localparam int ERR_OP   = 2;
   localparam int ERR_BUSY = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // MUL counts as a legal op only when the multiplier is built in.
   function automatic logic op_is_bad(input logic [2:0] code);
      case (code)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: op_is_bad = 1'b0;
`ifdef RPN_MUL_EN
         OP_MUL:                                op_is_bad = 1'b0;
`endif
         default:                               op_is_bad = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational RPN operator datapath: value = a op b, modulo 2^WIDTH.
// The multiply branch exists only when RPN_MUL_EN is defined.
module rpn_alu
   import rpn_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op_code,
   output logic [WIDTH-1:0] value,
   output logic             bad_op
);

   always_comb begin
      value  = '0;
      bad_op = op_is_bad(op_code);
      case (op_code)
         OP_ADD:  value = a + b;
         OP_SUB:  value = a - b;
`ifdef RPN_MUL_EN
         OP_MUL:  value = a * b;
`endif
         OP_AND:  value = a & b;
         OP_OR:   value = a | b;
         OP_XOR:  value = a ^ b;
         default: value = '0;
      endcase
   end

endmodule

// File: rtl/rpn_stack_eval.sv
// RPN evaluator: pushes operands onto a register stack, executes two-operand ops
// through IDLE -> EXEC -> WB. Define RPN_MUL_EN to enable the MUL operator.
module rpn_stack_eval
   import rpn_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_valid,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     op_valid,
   input  logic [2:0]               op_code,
   input  logic                     clear,
   output logic                     busy,
   output logic                     result_valid,
   output logic [WIDTH-1:0]         result,
   output logic [WIDTH-1:0]         top,
   output logic [$clog2(DEPTH):0]   depth,
   output logic [3:0]               err
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;

   state_t            state_reg, state_next;
   logic [DW-1:0]     depth_reg, depth_next;
   logic [3:0]        err_reg, err_next;
   logic              pend_valid_reg, pend_valid_next;
   logic [2:0]        pend_code_reg, pend_code_next;
   logic [2:0]        op_reg, op_next;
   logic [WIDTH-1:0]  alu_reg;
   logic [WIDTH-1:0]  result_reg, result_next;
   logic              result_valid_reg, result_valid_next;

   logic [WIDTH-1:0]  stack_mem [DEPTH];
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [WIDTH-1:0]  wr_data;

   logic [DW-1:0]     a_ptr, b_ptr;
   logic              op_req;
   logic [2:0]        op_sel, alu_op;
   logic [WIDTH-1:0]  alu_value;
   logic              alu_bad_op;

   assign a_ptr  = depth_reg - DW'(2);
   assign b_ptr  = depth_reg - DW'(1);
   assign op_req = pend_valid_reg | op_valid;
   assign op_sel = pend_valid_reg ? pend_code_reg : op_code;
   // In IDLE the ALU screens the candidate op; afterwards it evaluates the accepted one.
   assign alu_op = (state_reg == ST_IDLE) ? op_sel : op_reg;

   rpn_alu #(.WIDTH(WIDTH)) u_alu (
      .a       (stack_mem[a_ptr[AW-1:0]]),
      .b       (stack_mem[b_ptr[AW-1:0]]),
      .op_code (alu_op),
      .value   (alu_value),
      .bad_op  (alu_bad_op)
   );

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stack
         always_ff @(posedge clk) begin
            if (wr_en && wr_addr == AW'(gi))
               stack_mem[gi] <= wr_data;
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= ST_IDLE;
         depth_reg        <= '0;
         err_reg          <= '0;
         pend_valid_reg   <= 1'b0;
         pend_code_reg    <= '0;
         op_reg           <= '0;
         alu_reg          <= '0;
         result_reg       <= '0;
         result_valid_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         depth_reg        <= depth_next;
         err_reg          <= err_next;
         pend_valid_reg   <= pend_valid_next;
         pend_code_reg    <= pend_code_next;
         op_reg           <= op_next;
         result_reg       <= result_next;
         result_valid_reg <= result_valid_next;
         if (state_reg == ST_EXEC)
            alu_reg <= alu_value;
      end
   end

   always_comb begin
      state_next        = state_reg;
      depth_next        = depth_reg;
      err_next          = err_reg;
      pend_valid_next   = pend_valid_reg;
      pend_code_next    = pend_code_reg;
      op_next           = op_reg;
      result_next       = result_reg;
      result_valid_next = 1'b0;
      wr_en             = 1'b0;
      wr_addr           = '0;
      wr_data           = '0;

      if (clear) begin
         state_next      = ST_IDLE;
         depth_next      = '0;
         err_next        = '0;
         pend_valid_next = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (push_valid) begin
                  if (depth_reg == DW'(DEPTH)) begin
                     err_next[ERR_OVF] = 1'b1;
                  end else begin
                     wr_en      = 1'b1;
                     wr_addr    = depth_reg[AW-1:0];
                     wr_data    = push_data;
                     depth_next = depth_reg + DW'(1);
                  end
               end
               // A fresh op colliding with a held one has nowhere to go.
               if (pend_valid_reg && op_valid)
                  err_next[ERR_BUSY] = 1'b1;
               if (op_req) begin
                  if (push_valid) begin
                     pend_valid_next = 1'b1;
                     pend_code_next  = op_sel;
                  end else begin
                     pend_valid_next = 1'b0;
                     if (alu_bad_op)
                        err_next[ERR_OP] = 1'b1;
                     else if (depth_reg < DW'(2))
                        err_next[ERR_UNF] = 1'b1;
                     else begin
                        op_next    = op_sel;
                        state_next = ST_EXEC;
                     end
                  end
               end
            end
            ST_EXEC: begin
               if (push_valid || op_valid)
                  err_next[ERR_BUSY] = 1'b1;
               state_next = ST_WB;
            end
            ST_WB: begin
               if (push_valid || op_valid)
                  err_next[ERR_BUSY] = 1'b1;
               wr_en             = 1'b1;
               wr_addr           = a_ptr[AW-1:0];
               wr_data           = alu_reg;
               depth_next        = b_ptr;
               result_next       = alu_reg;
               result_valid_next = 1'b1;
               state_next        = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   assign busy         = (state_reg != ST_IDLE);
   assign result_valid = result_valid_reg;
   assign result       = result_reg;
   assign depth        = depth_reg;
   assign err          = err_reg;
   assign top          = (depth_reg == '0) ? '0 : stack_mem[b_ptr[AW-1:0]];

endmodule

// File: doc/rpn_stack_eval.md
Name: rpn_stack_eval

Overview:
- Downstream of digits_to_byte in the UART RPN calculator.
- Pushes each completed operand (digits_to_byte ready/dout) onto a register stack.
- On an operator token, pops two operands, computes, and pushes the result.
- Exposes top-of-stack and a result strobe for the UART TX formatter.

Parameters:
WIDTH, 16, operand/result width; must equal digits_to_byte dout width
DEPTH, 8, stack entries; power of two, >=2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
push_valid  in  1  operand strobe; wired to digits_to_byte ready
push_data  in  WIDTH  operand; wired to digits_to_byte dout
op_valid  in  1  operator strobe from tokenizer
op_code  in  3  0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6-7 reserved
clear  in  1  synchronous stack/error clear
busy  out  1  operator in progress
result_valid  out  1  one-cycle pulse when operator result written
result  out  WIDTH  operator result, held until next result
top  out  WIDTH  stack[depth-1]; 0 when empty
depth  out  $clog2(DEPTH)+1  current entry count
err  out  4  sticky {busy_drop, bad_op, underflow, overflow}

Behaviour:
- Reset, asynchronous: every output, stack pointer and pending register go to 0; state goes to IDLE. Stack RAM contents are don't-care.
- FSM: IDLE -> EXEC -> WB -> IDLE. busy=1 in EXEC and WB.
- Push (IDLE, push_valid): writes stack[depth], depth+1 at that edge. No busy, no result_valid.
- Push when depth==DEPTH: sets err[0]; stack unchanged.
- Op accepted in IDLE moves to EXEC. A = stack[depth-2], B = stack[depth-1].
  - EXEC registers A op B.
  - WB writes stack[depth-2], depth-1, result <= value, result_valid=1.
  - Result strobe arrives 2 cycles after the accept edge; next op accepted in WB+1.
- Arithmetic: unsigned, modulo 2^WIDTH. SUB = A-B (earlier operand minus later). MUL keeps the low WIDTH bits.
- Op with depth<2: err[1] set, returns to IDLE without EXEC; no result_valid, stack unchanged.
- Reserved op_code: err[2] set; no state change.
- push_valid or op_valid while busy: dropped, err[3] set.
- push_valid and op_valid in the same IDLE cycle: push is performed; op latched into a 1-entry pending register and accepted next cycle, as if re-presented.
- clear: highest priority after rst.
  - Takes effect at the next edge: depth=0, err=0, pending dropped, state=IDLE, result_valid=0.
  - result keeps its value.
  - Aborts EXEC/WB with no write.
- rst mid-EXEC/WB: immediate return to IDLE, depth 0, no result_valid.

Optional Feature:
- RPN_MUL_EN defined: op_code 2 multiplies, registered in EXEC.
- Undefined: op_code 2 is reserved. err[2] is set and no multiplier is synthesized.

Decomposition:
- Package rpn_pkg holds:
  - op-code localparams (OP_ADD..OP_XOR)
  - err bit indices (ERR_OVF=0, ERR_UNF=1, ERR_OP=2, ERR_BUSY=3)
  - FSM state encodings
- Sub-module rpn_alu: combinational A, B, op_code -> value, bad_op. The MUL branch is under RPN_MUL_EN.

Test Plan:
- Push 123, push 4, op ADD -> result_valid 2 cycles after accept; result=127, top=127, depth=1, err=0.
- Push 4, push 123, op SUB -> result=16'hFF89. Push 300, push 300, MUL -> 24464 with RPN_MUL_EN; without it, err=4'b0100, depth=2.
- Push 9 values at DEPTH=8 -> err[0]=1, depth=8, top=8th value. Clear -> depth=0, err=0. Op ADD with depth=1 -> err[1]=1, no result_valid.
- Push 5 and op ADD in the same cycle with stack [2] -> push then add; result=7, depth=1. Op_valid during EXEC -> err[3]=1, single result.
- Assert rst during EXEC after pushes 10, 20 and ADD -> outputs 0, no result_valid, depth=0. Next push 1 -> top=1.
